fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 28 ++
 rtl/fetch_queue_if.sv | 42 ++++
 rtl/fetch_queue.sv | 91 +++++++++
 tb/tb_fetch_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared CPU defines for the fetch queue: entry layout and fetch TLB exception flag encoding.
// Flags are packed {refill, invalid}, so a refill alone reads as 2'b10.
package fetch_queue_pkg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int EXC_W  = 2;

    localparam int EXC_REFILL  = 1;
    localparam int EXC_INVALID = 0;

    typedef logic [EXC_W-1:0] exc_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        exc_t              exc;
    } fq_entry_t;

    function automatic exc_t pack_exc(input logic refill, input logic invalid);
        exc_t e;
        e              = '0;
        e[EXC_REFILL]  = refill;
        e[EXC_INVALID] = invalid;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side signals of the fetch queue.
// Modport master belongs to the surrounding pipeline and modport slave to the queue.
interface fetch_queue_if #(
    parameter int DEPTH = 8
) ();
    import fetch_queue_pkg::*;

    logic                     flush;
    logic [PC_W-1:0]          fetch_pc;
    logic                     inst_ok_1;
    logic                     inst_ok_2;
    logic [INST_W-1:0]        inst_rdata_1;
    logic [INST_W-1:0]        inst_rdata_2;
    logic                     inst_tlb_refill_tlbl;
    logic                     inst_tlb_invalid_tlbl;
    logic                     fetch_stall;
    logic [1:0]               issue_cnt;
    logic                     out_valid_1;
    logic                     out_valid_2;
    logic [INST_W-1:0]        out_inst_1;
    logic [INST_W-1:0]        out_inst_2;
    logic [PC_W-1:0]          out_pc_1;
    logic [PC_W-1:0]          out_pc_2;
    exc_t                     out_exc_1;
    exc_t                     out_exc_2;
    logic [$clog2(DEPTH):0]   fq_count;

    modport master (
        output flush, fetch_pc, inst_ok_1, inst_ok_2, inst_rdata_1, inst_rdata_2,
               inst_tlb_refill_tlbl, inst_tlb_invalid_tlbl, issue_cnt,
        input  fetch_stall, out_valid_1, out_valid_2, out_inst_1, out_inst_2,
               out_pc_1, out_pc_2, out_exc_1, out_exc_2, fq_count
    );

    modport slave (
        input  flush, fetch_pc, inst_ok_1, inst_ok_2, inst_rdata_1, inst_rdata_2,
               inst_tlb_refill_tlbl, inst_tlb_invalid_tlbl, issue_cnt,
        output fetch_stall, out_valid_1, out_valid_2, out_inst_1, out_inst_2,
               out_pc_1, out_pc_2, out_exc_1, out_exc_2, fq_count
    );

endinterface

// File: rtl/fetch_queue.sv
// Dual-slot instruction fetch queue: circular register array with head/tail pointers,
// up to two pushes and two pops per cycle, flush to empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    fetch_queue_if.slave fq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    fq_entry_t mem [DEPTH];

    ptr_t     head;
    ptr_t     tail;
    cnt_t     count;

    logic     stall;
    logic     is_exc;
    logic     push_ok;
    logic     push_two;
    cnt_t     push_n;
    cnt_t     pop_n;
    logic [1:0] issue_eff;
    ptr_t     head_p1;
    ptr_t     tail_p1;

    // Stall looks only at the registered count so it never depends on same-cycle pops.
    assign stall   = (count > cnt_t'(DEPTH - 2));
    assign head_p1 = head + ptr_t'(1);
    assign tail_p1 = tail + ptr_t'(1);

    always_comb begin
        is_exc    = fq.inst_tlb_refill_tlbl | fq.inst_tlb_invalid_tlbl;
        push_ok   = fq.inst_ok_1 & ~stall;
        push_two  = push_ok & ~is_exc & fq.inst_ok_2;
        push_n    = '0;
        if (push_ok) begin
            push_n = push_two ? cnt_t'(2) : cnt_t'(1);
        end
        issue_eff = (fq.issue_cnt == 2'd3) ? 2'd2 : fq.issue_cnt;
        pop_n     = (cnt_t'(issue_eff) > count) ? count : cnt_t'(issue_eff);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (fq.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + ptr_t'(pop_n);
            tail  <= tail + ptr_t'(push_n);
            count <= count + push_n - pop_n;
        end
    end

    // Storage is not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail] <= '{pc:   fq.fetch_pc,
                           inst: is_exc ? '0 : fq.inst_rdata_1,
                           exc:  pack_exc(fq.inst_tlb_refill_tlbl, fq.inst_tlb_invalid_tlbl)};
            if (push_two) begin
                mem[tail_p1] <= '{pc: fq.fetch_pc + 32'd4, inst: fq.inst_rdata_2, exc: '0};
            end
        end
    end

    assign fq.fetch_stall = stall;
    assign fq.fq_count    = count;
    assign fq.out_valid_1 = (count != '0);
    assign fq.out_valid_2 = (count >= cnt_t'(2));
    assign fq.out_pc_1    = mem[head].pc;
    assign fq.out_pc_2    = mem[head_p1].pc;
    assign fq.out_inst_1  = mem[head].inst;
    assign fq.out_inst_2  = mem[head_p1].inst;
    assign fq.out_exc_1   = fq.out_valid_1 ? mem[head].exc : '0;
    assign fq.out_exc_2   = fq.out_valid_2 ? mem[head_p1].exc : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model, plus directed scenarios.
module tb_fetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  exc;
    } ent_t;

    localparam int DEPTH = 8;

    logic clk;
    logic resetn;
    int   n_vec;
    int   n_bad;
    ent_t q[$];

    fetch_queue_if #(.DEPTH(DEPTH)) fq();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .fq     (fq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = q.size();
        chk("fq_count", 64'(fq.fq_count), 64'(sz));
        chk("out_valid_1", 64'(fq.out_valid_1), 64'(sz >= 1));
        chk("out_valid_2", 64'(fq.out_valid_2), 64'(sz >= 2));
        chk("fetch_stall", 64'(fq.fetch_stall), 64'((DEPTH - sz) < 2));
        if (sz >= 1) begin
            chk("out_pc_1", 64'(fq.out_pc_1), 64'(q[0].pc));
            chk("out_inst_1", 64'(fq.out_inst_1), 64'(q[0].inst));
            chk("out_exc_1", 64'(fq.out_exc_1), 64'(q[0].exc));
        end else begin
            chk("out_exc_1_idle", 64'(fq.out_exc_1), 64'(0));
        end
        if (sz >= 2) begin
            chk("out_pc_2", 64'(fq.out_pc_2), 64'(q[1].pc));
            chk("out_inst_2", 64'(fq.out_inst_2), 64'(q[1].inst));
            chk("out_exc_2", 64'(fq.out_exc_2), 64'(q[1].exc));
        end else begin
            chk("out_exc_2_idle", 64'(fq.out_exc_2), 64'(0));
        end
    endtask

    task automatic drive_idle();
        fq.flush                 = 1'b0;
        fq.fetch_pc              = '0;
        fq.inst_ok_1             = 1'b0;
        fq.inst_ok_2             = 1'b0;
        fq.inst_rdata_1          = '0;
        fq.inst_rdata_2          = '0;
        fq.inst_tlb_refill_tlbl  = 1'b0;
        fq.inst_tlb_invalid_tlbl = 1'b0;
        fq.issue_cnt             = 2'd0;
    endtask

    // One clock of stimulus; the model applies the queue rules to the pre-edge contents.
    task automatic step(input logic ok1, input logic ok2, input logic refill, input logic invalid,
                        input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [1:0] ic, input logic fl);
        int   pops;
        ent_t e;
        @(negedge clk);
        fq.flush                 = fl;
        fq.fetch_pc              = pc;
        fq.inst_ok_1             = ok1;
        fq.inst_ok_2             = ok2;
        fq.inst_rdata_1          = d1;
        fq.inst_rdata_2          = d2;
        fq.inst_tlb_refill_tlbl  = refill;
        fq.inst_tlb_invalid_tlbl = invalid;
        fq.issue_cnt             = ic;
        if (fl) begin
            q.delete();
        end else begin
            pops = (ic == 2'd3) ? 2 : int'(ic);
            if (pops > q.size()) pops = q.size();
            if (ok1 && (DEPTH - q.size()) >= 2) begin
                if (refill || invalid) begin
                    e.pc = pc; e.inst = 32'h0; e.exc = {refill, invalid};
                    q.push_back(e);
                end else begin
                    e.pc = pc; e.inst = d1; e.exc = 2'b00;
                    q.push_back(e);
                    if (ok2) begin
                        e.pc = pc + 32'd4; e.inst = d2; e.exc = 2'b00;
                        q.push_back(e);
                    end
                end
            end
            for (int i = 0; i < pops; i++) void'(q.pop_front());
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        drive_idle();
        #1 resetn = 1'b0;
        #1;
        q.delete();
        chk("rst_count", 64'(fq.fq_count), 64'(0));
        chk("rst_valid_1", 64'(fq.out_valid_1), 64'(0));
        chk("rst_valid_2", 64'(fq.out_valid_2), 64'(0));
        chk("rst_exc_1", 64'(fq.out_exc_1), 64'(0));
        chk("rst_exc_2", 64'(fq.out_exc_2), 64'(0));
        chk("rst_stall", 64'(fq.fetch_stall), 64'(0));
        #1 resetn = 1'b1;
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        resetn = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("init_count", 64'(fq.fq_count), 64'(0));
        chk("init_valid_1", 64'(fq.out_valid_1), 64'(0));
        chk("init_stall", 64'(fq.fetch_stall), 64'(0));
        chk("init_exc_1", 64'(fq.out_exc_1), 64'(0));
        @(negedge clk);
        resetn = 1'b1;

        // Boot fetch: two instructions visible one cycle later
        step(1, 1, 0, 0, 32'hBFC00000, 32'h24010001, 32'h24020002, 2'd0, 0);
        chk("boot_valid_2", 64'(fq.out_valid_2), 64'(1));
        chk("boot_pc_2", 64'(fq.out_pc_2), 64'hBFC00004);
        chk("boot_count", 64'(fq.fq_count), 64'(2));

        // Fill to full; pushes at count 6 still accepted, later ones dropped
        for (int i = 1; i < 4; i++)
            step(1, 1, 0, 0, 32'hBFC00000 + 32'(8 * i), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 2'd0, 0);
        chk("full_count", 64'(fq.fq_count), 64'(8));
        chk("full_stall", 64'(fq.fetch_stall), 64'(1));
        step(1, 1, 0, 0, 32'h00001000, 32'hDEAD0001, 32'hDEAD0002, 2'd0, 0);
        chk("drop_count", 64'(fq.fq_count), 64'(8));

        // Drain to 3, then push 2 / pop 2 across the pointer wrap
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'd1, 0);
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'd2, 0);
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'd3, 0);
        chk("drain_count", 64'(fq.fq_count), 64'(3));
        step(1, 1, 0, 0, 32'h80000100, 32'hA1, 32'hA2, 2'd2, 0);
        step(1, 1, 0, 0, 32'h80000108, 32'hB1, 32'hB2, 2'd2, 0);
        chk("wrap_count", 64'(fq.fq_count), 64'(3));

        // Flush at count 5 overrides push and pop
        step(1, 1, 0, 0, 32'h80000110, 32'hC1, 32'hC2, 2'd0, 0);
        chk("pre_flush_count", 64'(fq.fq_count), 64'(5));
        step(1, 1, 0, 0, 32'h80000118, 32'hD1, 32'hD2, 2'd2, 1);
        chk("flush_count", 64'(fq.fq_count), 64'(0));
        chk("flush_valid_1", 64'(fq.out_valid_1), 64'(0));

        // TLB refill push: single entry with zeroed instruction
        step(1, 1, 1, 0, 32'h00400000, 32'h12345678, 32'h9ABCDEF0, 2'd0, 0);
        chk("exc_flags", 64'(fq.out_exc_1), 64'(2'b10));
        chk("exc_inst", 64'(fq.out_inst_1), 64'(0));
        chk("exc_count", 64'(fq.fq_count), 64'(1));

        // Over-issue from a single entry
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'd2, 0);
        chk("underflow_count", 64'(fq.fq_count), 64'(0));

        // ok_2 alone is ignored
        step(0, 1, 0, 0, 32'h00500000, 32'h1, 32'h2, 2'd0, 0);
        chk("ok2_only_count", 64'(fq.fq_count), 64'(0));

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                     {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, $urandom, $urandom,
                     2'($urandom_range(0, 3)), $urandom_range(0, 31) == 0);
            end
        end

        step(1, 1, 0, 0, 32'h00600000, 32'h11, 32'h22, 2'd0, 0);
        step(1, 1, 0, 0, 32'h00600008, 32'h33, 32'h44, 2'd0, 0);
        pulse_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
